// File: rtl/note_sequencer.sv
// note_sequencer
//
// Steps through one of two fixed note charts on a beat strobe and emits one
// lane code per step for the note-rendering/judging logic. Supports song
// selection, a per-song chart length, pause/resume, abort and an
// end-of-song pulse.
//
// Parameters:
//   NOTE_W    width of the lane code
//   STEP_W    width of the step index
//   LEN0      song 0 length in steps (1 .. 2**STEP_W)
//   LEN1      song 1 length in steps (1 .. 2**STEP_W)
//   REST_NOTE lane code shown when no chart note is active
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   step_tick   one-cycle beat strobe
//   start       one-cycle pulse, begins playback from IDLE or DONE
//   song_sel    chart select, sampled only when start is accepted
//   pause       one-cycle pulse, suspends playback (PLAY only)
//   resume      one-cycle pulse, continues playback (PAUSE only)
//   abort       one-cycle pulse, returns to IDLE from any state
//   note        current lane code (registered)
//   note_valid  one-cycle pulse when a chart note is emitted
//   step        index of the next step to emit
//   busy        high in PLAY or PAUSE
//   done        one-cycle pulse together with the final note_valid
module note_sequencer #(
  parameter int NOTE_W    = 3,
  parameter int STEP_W    = 8,
  parameter int LEN0      = 16,
  parameter int LEN1      = 24,
  parameter int REST_NOTE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_tick,
  input  logic              start,
  input  logic              song_sel,
  input  logic              pause,
  input  logic              resume,
  input  logic              abort,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last step index of each song, truncated to STEP_W so that a length of
  // exactly 2**STEP_W compares against the all-ones index.
  localparam logic [STEP_W-1:0] LAST0 = STEP_W'(LEN0 - 1);
  localparam logic [STEP_W-1:0] LAST1 = STEP_W'(LEN1 - 1);
  localparam logic [NOTE_W-1:0] REST  = NOTE_W'(REST_NOTE);

  state_t              state_q, state_d;
  logic                song_q,  song_d;
  logic [NOTE_W-1:0]   note_d;
  logic [STEP_W-1:0]   step_d;
  logic                note_valid_d;
  logic                done_d;
  logic [STEP_W-1:0]   last_step;

  // Chart ROM: song 0 plays lane 3 for the first eleven steps then lane 2;
  // song 1 cycles through lanes 0..3.
  function automatic logic [NOTE_W-1:0] chart_note(input logic sel,
                                                   input logic [STEP_W-1:0] k);
    logic [NOTE_W-1:0] n;
    unique case (sel)
      1'b0:    n = (int'(k) < 11) ? NOTE_W'(3) : NOTE_W'(2);
      default: n = NOTE_W'(k[1:0]);
    endcase
    return n;
  endfunction

  assign last_step = song_q ? LAST1 : LAST0;

  // Next-state and next-output decode. Priority when inputs coincide:
  // abort > pause > resume > start > step_tick. Inputs that do not apply to
  // the current state are ignored and do not mask lower-priority ones.
  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    note_d       = note;
    step_d       = step;
    note_valid_d = 1'b0;
    done_d       = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      note_d  = REST;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          note_d = REST;
          if (start) begin
            state_d = S_PLAY;
            song_d  = song_sel;
            step_d  = '0;
          end
        end

        S_PLAY: begin
          if (pause) begin
            state_d = S_PAUSE;
            note_d  = REST;
          end else if (step_tick) begin
            note_d       = chart_note(song_q, step);
            note_valid_d = 1'b1;
            if (step == last_step) begin
              // Final step: the end-of-song pulse rides with this note.
              state_d = S_DONE;
              done_d  = 1'b1;
              step_d  = '0;
            end else begin
              step_d = step + 1'b1;
            end
          end
        end

        S_PAUSE: begin
          note_d = REST;
          if (resume) begin
            state_d = S_PLAY;
          end
        end

        default: begin
          state_d = S_IDLE;
          note_d  = REST;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      song_q     <= 1'b0;
      note       <= REST;
      note_valid <= 1'b0;
      step       <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      note       <= note_d;
      note_valid <= note_valid_d;
      step       <= step_d;
      done       <= done_d;
    end
  end

  assign busy = (state_q == S_PLAY) | (state_q == S_PAUSE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a reference model tracks playback state and pushes
// the expected note/done/step of every emission into a queue; a monitor pops
// and compares on each note_valid. A second instance with STEP_W = 4 and a
// 16-step song exercises the full-range step wrap.
module tb_note_sequencer;

  localparam int NOTE_W = 3;
  localparam int STEP_W = 8;
  localparam int LEN0   = 16;
  localparam int LEN1   = 24;
  localparam int REST   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_tick = 1'b0, start = 1'b0, song_sel = 1'b0;
  logic pause = 1'b0, resume = 1'b0, abort = 1'b0;

  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              done;

  logic [NOTE_W-1:0] e_note;
  logic              e_note_valid;
  logic [3:0]        e_step;
  logic              e_busy;
  logic              e_done;

  note_sequencer #(
    .NOTE_W(NOTE_W), .STEP_W(STEP_W), .LEN0(LEN0), .LEN1(LEN1), .REST_NOTE(REST)
  ) dut (
    .clk(clk), .rst(rst), .step_tick(step_tick), .start(start),
    .song_sel(song_sel), .pause(pause), .resume(resume), .abort(abort),
    .note(note), .note_valid(note_valid), .step(step), .busy(busy), .done(done)
  );

  note_sequencer #(
    .NOTE_W(NOTE_W), .STEP_W(4), .LEN0(16), .LEN1(16), .REST_NOTE(REST)
  ) u_edge (
    .clk(clk), .rst(rst), .step_tick(step_tick), .start(start),
    .song_sel(song_sel), .pause(pause), .resume(resume), .abort(abort),
    .note(e_note), .note_valid(e_note_valid), .step(e_step), .busy(e_busy),
    .done(e_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of the main instance
  typedef enum int {M_IDLE, M_PLAY, M_PAUSE, M_DONE} mstate_t;
  typedef struct {
    int note;
    int done;
    int step;
  } exp_t;

  mstate_t m_state = M_IDLE;
  int      m_step  = 0;
  bit      m_song  = 1'b0;
  exp_t    sbq[$];
  exp_t    mon_e;

  function automatic int ref_note(input bit song, input int k);
    if (song) return k % 4;
    return (k < 11) ? 3 : 2;
  endfunction

  // One clock of stimulus: check steady outputs, apply inputs at the falling
  // edge, update the model, and release the pulses just after the rising edge.
  task automatic drive(input bit tk, st, sel, ps, rs, ab);
    exp_t e;
    int   len;
    @(negedge clk);
    check("busy", busy, (m_state == M_PLAY || m_state == M_PAUSE));
    check("step", step, m_step);
    if (m_state == M_IDLE || m_state == M_PAUSE)
      check("rest_note", note, REST);
    step_tick = tk; start = st; song_sel = sel;
    pause = ps; resume = rs; abort = ab;
    if (rst) begin
      len = m_song ? LEN1 : LEN0;
      if (ab) begin
        m_state = M_IDLE;
        m_step  = 0;
      end else if (m_state == M_PLAY && ps) begin
        m_state = M_PAUSE;
      end else if (m_state == M_PAUSE && rs) begin
        m_state = M_PLAY;
      end else if ((m_state == M_IDLE || m_state == M_DONE) && st) begin
        m_state = M_PLAY;
        m_song  = sel;
        m_step  = 0;
      end else if (m_state == M_PLAY && tk) begin
        e.note = ref_note(m_song, m_step);
        e.done = (m_step == len - 1) ? 1 : 0;
        m_step = e.done ? 0 : m_step + 1;
        e.step = m_step;
        sbq.push_back(e);
        if (e.done != 0) m_state = M_DONE;
      end
    end
    @(posedge clk);
    #1;
    step_tick = 1'b0; start = 1'b0; song_sel = 1'b0;
    pause = 1'b0; resume = 1'b0; abort = 1'b0;
  endtask

  task automatic tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go(input bit sel);
    drive(1'b0, 1'b1, sel, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (note_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_note_valid", note_valid, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_note", note, mon_e.note);
        check("sb_done", done, mon_e.done);
        check("sb_step", step, mon_e.step);
      end
    end else begin
      check("done_without_valid", done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  int wraps;

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_note", note, REST);
    check("rst_valid", note_valid, 0);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Song 0 full run, ticks spaced out
    go(1'b0);
    check("start_busy", busy, 1);
    for (int k = 0; k < LEN0; k++) begin
      tick();
      idle(1);
    end
    check("s0_note_after", note, REST);
    check("s0_busy_after", busy, 0);
    check("s0_drained", sbq.size(), 0);

    // Song 1 with back-to-back ticks
    go(1'b1);
    for (int k = 0; k < LEN1; k++) tick();
    idle(2);
    check("s1_drained", sbq.size(), 0);
    check("s1_step_zero", step, 0);

    // Pause / resume
    go(1'b0);
    for (int k = 0; k < 4; k++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_note", note, REST);
    check("pause_step", step, 4);
    check("pause_busy", busy, 1);
    for (int k = 0; k < 3; k++) tick();
    check("pause_hold_step", step, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resume_no_emit", note_valid, 0);
    tick();
    check("resume_note", note, 3);
    check("resume_step", step, 5);

    // abort + pause + tick together in PLAY
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("abort_valid", note_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_note", note, REST);
    check("abort_step", step, 0);
    idle(1);

    // start while busy is ignored
    go(1'b1);
    for (int k = 0; k < 3; k++) tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_start_note", note, 3);
    check("busy_start_step", step, 4);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_start_hold", step, 4);
    tick();
    check("busy_start_song", note, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // start with tick in IDLE: no emission that cycle
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_tick_valid", note_valid, 0);
    check("start_tick_step", step, 0);

    // Asynchronous reset at step 5
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_state = M_IDLE;
    m_step  = 0;
    check("arst_note", note, REST);
    check("arst_step", step, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_valid", note_valid, 0);
    for (int k = 0; k < 2; k++) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("arst_idle_note", note, REST);
    check("arst_idle_busy", busy, 0);

    // Full-range step wrap on the STEP_W = 4 instance
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    go(1'b0);
    check("edge_busy", e_busy, 1);
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("edge_valid", e_note_valid, 1);
      check("edge_note", e_note, ref_note(1'b0, k));
      check("edge_done", e_done, (k == 15) ? 1 : 0);
      check("edge_step", e_step, (k + 1) % 16);
      if (k == 15 && e_step == 4'd0) wraps++;
    end
    check("edge_wrap_count", wraps, 1);
    idle(1);
    check("edge_busy_after", e_busy, 0);
    check("edge_note_after", e_note, REST);
    go(1'b0);
    tick();
    check("edge_replay_note", e_note, 3);
    check("edge_replay_step", e_step, 1);
    check("edge_replay_valid", e_note_valid, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    idle(2);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
